// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
// No logic, no latency.
// No flow control; consumers import what they need.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_RESET  = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of fetch-stage control inputs, instruction memory port and IF/ID outputs.
// Pure wiring, no latency.
// stall from decode is the only backpressure; it freezes PC and IF/ID.
interface fetch_stage_if;
  logic        stall;
  logic        desvio;
  logic [31:0] alvoDesvio;
  logic [31:0] imemDado;
  logic [31:0] imemEndereco;
  logic [31:0] instrucao;
  logic [31:0] pcID;
  logic        validoID;
  logic        parado;
  logic        erroAlinhamento;
  logic [31:0] contBusca;

  // Environment side: drives control and memory data, observes fetch results.
  modport master (
    output stall, desvio, alvoDesvio, imemDado,
    input  imemEndereco, instrucao, pcID, validoID, parado, erroAlinhamento, contBusca
  );

  // Fetch stage side.
  modport slave (
    input  stall, desvio, alvoDesvio, imemDado,
    output imemEndereco, instrucao, pcID, validoID, parado, erroAlinhamento, contBusca
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register holding instruction, its PC and a valid bit.
// One cycle: inputs captured on the rising edge when load is set.
// hold (or no control) keeps contents; bubble inserts a NOP with valid cleared.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instrucao,
  output logic [31:0] pcID,
  output logic        validoID
);

  // Reset beats bubble beats load; hold suppresses load. pcID is left alone on a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      instrucao <= NOP_WORD;
      pcID      <= PC_RESET;
      validoID  <= 1'b0;
    end else if (bubble) begin
      instrucao <= NOP_WORD;
      validoID  <= 1'b0;
    end else if (load && !hold) begin
      instrucao <= instr_in;
      pcID      <= pc_in;
      validoID  <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALT control, fetch counter, IF/ID register.
// One cycle from word at PC to instrucao; imemEndereco is a direct copy of PC.
// stall holds PC and IF/ID; desvio overrides stall; HALT ignores both until reset.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  fetch_stage_if.slave   bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         ifid_load;
  logic         ifid_hold;
  logic         ifid_bubble;

  assign bus.imemEndereco = pc;

  // Decide what the IF/ID register does this cycle, following redirect > stall > halt > fetch.
  always_comb begin
    ifid_load   = 1'b0;
    ifid_hold   = 1'b0;
    ifid_bubble = 1'b0;
    case (state)
      ST_RUN: begin
        if (bus.desvio)                    ifid_bubble = 1'b1;
        else if (bus.stall)                ifid_hold   = 1'b1;
        else if (bus.imemDado == HALT_WORD) ifid_bubble = 1'b1;
        else                               ifid_load   = 1'b1;
      end
      default: ifid_bubble = 1'b1;
    endcase
  end

  // State machine with PC, halt flag, sticky alignment error and fetch counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= ST_BOOT;
      pc                  <= PC_RESET;
      bus.parado          <= 1'b0;
      bus.erroAlinhamento <= 1'b0;
      bus.contBusca       <= 32'd0;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN: begin
          if (bus.desvio) begin
            pc <= {bus.alvoDesvio[31:2], 2'b00};
            if (bus.alvoDesvio[1:0] != 2'b00) bus.erroAlinhamento <= 1'b1;
          end else if (bus.stall) begin
            pc <= pc;
          end else if (bus.imemDado == HALT_WORD) begin
            state      <= ST_HALT;
            bus.parado <= 1'b1;
          end else begin
            pc            <= pc + PC_INCR;
            bus.contBusca <= bus.contBusca + 32'd1;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_BOOT;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (ifid_load),
    .hold      (ifid_hold),
    .bubble    (ifid_bubble),
    .instr_in  (bus.imemDado),
    .pc_in     (pc),
    .instrucao (bus.instrucao),
    .pcID      (bus.pcID),
    .validoID  (bus.validoID)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction ROM model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task carries its own hand-computed expectations.
module tb_fetch_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] mem [0:63];

  fetch_stage_if bus ();

  fetch_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ROM: first 256 bytes from mem, everything else reads a fixed non-halt word.
  always_comb begin
    if (bus.imemEndereco < 32'h100) bus.imemDado = mem[bus.imemEndereco[7:2]];
    else                            bus.imemDado = 32'h0000_0093;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.desvio = 1'b0;
    bus.alvoDesvio = 32'h0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.stall = 1'b1;
    bus.desvio = 1'b1;
    bus.alvoDesvio = 32'h0000_0080;
    reset = 1'b1;
    tick();
    tick();
    vectors++; if (bus.imemEndereco !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp %h", bus.imemEndereco, 32'h0); end
    vectors++; if (bus.instrucao !== 32'h13) begin miscompares++; $display("FAIL reset_instr got %h exp %h", bus.instrucao, 32'h13); end
    vectors++; if (bus.pcID !== 32'h0) begin miscompares++; $display("FAIL reset_pcid got %h exp %h", bus.pcID, 32'h0); end
    vectors++; if ({bus.validoID, bus.parado, bus.erroAlinhamento} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {bus.validoID, bus.parado, bus.erroAlinhamento}); end
    vectors++; if (bus.contBusca !== 32'h0) begin miscompares++; $display("FAIL reset_count got %h exp %h", bus.contBusca, 32'h0); end
  endtask

  task automatic test_fetch();
    apply_reset();
    tick();  // BOOT cycle
    vectors++; if (bus.validoID !== 1'b0 || bus.imemEndereco !== 32'h0) begin miscompares++; $display("FAIL boot_hold got v=%b pc=%h exp v=0 pc=0", bus.validoID, bus.imemEndereco); end
    tick();
    vectors++; if (bus.instrucao !== 32'h0040_0003 || bus.pcID !== 32'h0 || bus.validoID !== 1'b1) begin miscompares++; $display("FAIL fetch0 got %h@%h v=%b exp 00400003@0 v=1", bus.instrucao, bus.pcID, bus.validoID); end
    tick();
    vectors++; if (bus.instrucao !== 32'h00A0_0023 || bus.pcID !== 32'h4) begin miscompares++; $display("FAIL fetch1 got %h@%h exp 00a00023@4", bus.instrucao, bus.pcID); end
    tick();
    vectors++; if (bus.instrucao !== 32'h00B5_1463 || bus.pcID !== 32'h8) begin miscompares++; $display("FAIL fetch2 got %h@%h exp 00b51463@8", bus.instrucao, bus.pcID); end
    vectors++; if (bus.contBusca !== 32'd3) begin miscompares++; $display("FAIL fetch_count got %0d exp 3", bus.contBusca); end
  endtask

  task automatic test_stall();
    apply_reset();
    tick();
    tick();
    tick();  // pcID now 0x4, PC 0x8
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (bus.imemEndereco !== 32'h8 || bus.instrucao !== 32'h00A0_0023 || bus.pcID !== 32'h4 || bus.contBusca !== 32'd2) begin
        miscompares++; $display("FAIL stall_hold%0d got pc=%h i=%h pcid=%h n=%0d exp pc=8 i=00a00023 pcid=4 n=2", i, bus.imemEndereco, bus.instrucao, bus.pcID, bus.contBusca);
      end
    end
    bus.stall = 1'b0;
    tick();
    vectors++; if (bus.pcID !== 32'h8 || bus.contBusca !== 32'd3 || bus.imemEndereco !== 32'hC) begin miscompares++; $display("FAIL stall_resume got pcid=%h n=%0d pc=%h exp pcid=8 n=3 pc=c", bus.pcID, bus.contBusca, bus.imemEndereco); end
  endtask

  task automatic test_branch_under_stall();
    bus.stall = 1'b1;
    bus.desvio = 1'b1;
    bus.alvoDesvio = 32'h0000_0040;
    tick();
    bus.stall = 1'b0;
    bus.desvio = 1'b0;
    vectors++; if (bus.validoID !== 1'b0 || bus.instrucao !== 32'h13 || bus.imemEndereco !== 32'h40) begin miscompares++; $display("FAIL branch_bubble got v=%b i=%h pc=%h exp v=0 i=13 pc=40", bus.validoID, bus.instrucao, bus.imemEndereco); end
    vectors++; if (bus.contBusca !== 32'd3) begin miscompares++; $display("FAIL branch_count got %0d exp 3", bus.contBusca); end
    tick();
    vectors++; if (bus.pcID !== 32'h40 || bus.instrucao !== 32'h00C5_8593 || bus.validoID !== 1'b1 || bus.contBusca !== 32'd4) begin
      miscompares++; $display("FAIL branch_target got %h@%h v=%b n=%0d exp 00c58593@40 v=1 n=4", bus.instrucao, bus.pcID, bus.validoID, bus.contBusca);
    end
  endtask

  task automatic test_misalign();
    vectors++; if (bus.erroAlinhamento !== 1'b0) begin miscompares++; $display("FAIL align_pre got %b exp 0", bus.erroAlinhamento); end
    bus.desvio = 1'b1;
    bus.alvoDesvio = 32'h0000_0042;
    tick();
    bus.desvio = 1'b0;
    vectors++; if (bus.imemEndereco !== 32'h40 || bus.erroAlinhamento !== 1'b1) begin miscompares++; $display("FAIL align_set got pc=%h e=%b exp pc=40 e=1", bus.imemEndereco, bus.erroAlinhamento); end
    tick();
    tick();
    tick();
    vectors++; if (bus.erroAlinhamento !== 1'b1 || bus.imemEndereco !== 32'h4C) begin miscompares++; $display("FAIL align_sticky got e=%b pc=%h exp e=1 pc=4c", bus.erroAlinhamento, bus.imemEndereco); end
  endtask

  task automatic test_halt();
    mem[4] = 32'h0;  // halt word at 0x10
    apply_reset();
    for (int i = 0; i < 5; i++) tick();
    vectors++; if (bus.parado !== 1'b0 || bus.imemEndereco !== 32'h10) begin miscompares++; $display("FAIL halt_pre got p=%b pc=%h exp p=0 pc=10", bus.parado, bus.imemEndereco); end
    tick();
    vectors++; if (bus.parado !== 1'b1 || bus.imemEndereco !== 32'h10 || bus.validoID !== 1'b0 || bus.instrucao !== 32'h13 || bus.contBusca !== 32'd4) begin
      miscompares++; $display("FAIL halt_enter got p=%b pc=%h v=%b i=%h n=%0d exp p=1 pc=10 v=0 i=13 n=4", bus.parado, bus.imemEndereco, bus.validoID, bus.instrucao, bus.contBusca);
    end
    bus.desvio = 1'b1;
    bus.alvoDesvio = 32'h0000_0082;
    tick();
    tick();
    vectors++; if (bus.parado !== 1'b1 || bus.imemEndereco !== 32'h10 || bus.erroAlinhamento !== 1'b0) begin miscompares++; $display("FAIL halt_ignore got p=%b pc=%h e=%b exp p=1 pc=10 e=0", bus.parado, bus.imemEndereco, bus.erroAlinhamento); end
    bus.stall = 1'b1;
    reset = 1'b1;
    tick();
    vectors++; if (bus.parado !== 1'b0 || bus.imemEndereco !== 32'h0 || bus.instrucao !== 32'h13 || bus.pcID !== 32'h0 || bus.validoID !== 1'b0 || bus.contBusca !== 32'h0) begin
      miscompares++; $display("FAIL halt_reset got p=%b pc=%h i=%h pcid=%h v=%b n=%0d exp all reset values", bus.parado, bus.imemEndereco, bus.instrucao, bus.pcID, bus.validoID, bus.contBusca);
    end
    mem[4] = 32'h13;
  endtask

  task automatic test_wrap();
    apply_reset();
    tick();  // BOOT
    bus.desvio = 1'b1;
    bus.alvoDesvio = 32'hFFFF_FFFC;
    tick();
    bus.desvio = 1'b0;
    vectors++; if (bus.imemEndereco !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_redirect got %h exp fffffffc", bus.imemEndereco); end
    tick();
    vectors++; if (bus.imemEndereco !== 32'h0 || bus.pcID !== 32'hFFFF_FFFC || bus.instrucao !== 32'h93 || bus.validoID !== 1'b1) begin
      miscompares++; $display("FAIL wrap_fetch got pc=%h pcid=%h i=%h v=%b exp pc=0 pcid=fffffffc i=93 v=1", bus.imemEndereco, bus.pcID, bus.instrucao, bus.validoID);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h0040_0003;
    mem[1]  = 32'h00A0_0023;
    mem[2]  = 32'h00B5_1463;
    mem[16] = 32'h00C5_8593;
    bus.stall = 1'b0;
    bus.desvio = 1'b0;
    bus.alvoDesvio = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_branch_under_stall();
    test_misalign();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-003 SHALL have port stall  input  1  hazard hold request from decode; freezes PC and IF/ID register.
REQ-004 SHALL have port desvio  input  1  taken-branch redirect from execute.
REQ-005 SHALL have port alvoDesvio  input  32  branch target address.
REQ-006 SHALL have port imemDado  input  32  instruction word read combinationally at imemEndereco.
REQ-007 SHALL have port imemEndereco  output  32  current PC; combinational copy of PC register.
REQ-008 SHALL have port instrucao  output  32  registered IF/ID instruction; feeds decode and immediate generation.
REQ-009 SHALL have port pcID  output  32  registered PC of instrucao.
REQ-010 SHALL have port validoID  output  1  instrucao/pcID hold a real fetched instruction.
REQ-011 SHALL have port parado  output  1  high while in HALT state.
REQ-012 SHALL have port erroAlinhamento  output  1  sticky flag: a redirect target had nonzero bits [1:0].
REQ-013 SHALL have port contBusca  output  32  count of instructions latched valid into IF/ID.

Function
REQ-014 SHALL implement states BOOT, RUN, HALT; reset enters BOOT.
REQ-015 BOOT SHALL last exactly one cycle: no PC advance, validoID=0, then unconditional transition to RUN.
REQ-016 In RUN, with no stall and no desvio and imemDado != 0x00000000: PC <= PC+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000); instrucao <= imemDado; pcID <= PC; validoID <= 1; contBusca += 1.
REQ-017 Fetch-to-IF/ID latency SHALL be one cycle: word at PC in cycle N appears on instrucao in cycle N+1.
REQ-018 Priority per cycle SHALL be reset > desvio > stall > halt detection > normal fetch.
REQ-019 desvio=1 in RUN: PC <= {alvoDesvio[31:2],2'b00}; instrucao <= NOP 0x00000013; validoID <= 0; contBusca unchanged; applies even when stall=1.
REQ-020 desvio=1 with alvoDesvio[1:0] != 0 SHALL set erroAlinhamento; it clears only on reset.
REQ-021 stall=1 (no desvio) in RUN: PC, instrucao, pcID, validoID, contBusca all hold.
REQ-022 In RUN, no stall, no desvio, imemDado == 0x00000000: transition to HALT; PC holds; instrucao <= NOP; validoID <= 0.
REQ-023 HALT SHALL ignore stall and desvio; PC holds; validoID=0; parado=1; only reset exits.
REQ-024 contBusca SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-025 imemEndereco SHALL always equal the PC register, including during BOOT and HALT.

Reset
REQ-026 On reset: PC=0x00000000, instrucao=0x00000013, pcID=0x00000000, validoID=0, parado=0, erroAlinhamento=0, contBusca=0, state=BOOT.
REQ-027 Reset asserted mid-operation, including in HALT or simultaneously with desvio/stall, SHALL override all and produce REQ-026 values on the next edge.

Structure
REQ-028 A shared package SHALL hold the state encoding, PC_RESET (0x00000000), NOP_WORD (0x00000013), HALT_WORD (0x00000000), and PC_INCR (4).
REQ-029 The IF/ID register (instrucao, pcID, validoID with load, hold, bubble controls) SHALL be one sub-module named if_id_reg; PC, FSM, and counter stay in fetch_stage.

Verification
REQ-030 Reset, ROM words 0x00400003, 0x00A00023, 0x00B51463 at 0x0,0x4,0x8 -> BOOT one cycle; then instrucao shows these words on consecutive cycles with pcID 0x0,0x4,0x8; contBusca=3.
REQ-031 stall=1 for 2 cycles after pcID=0x4 -> PC=0x8, instrucao=0x00A00023 held 2 extra cycles; contBusca unchanged.
REQ-032 desvio=1, alvoDesvio=0x00000040, with stall=1 in the same cycle -> next cycle validoID=0, instrucao=0x00000013, imemEndereco=0x40; the cycle after, pcID=0x40.
REQ-033 desvio=1, alvoDesvio=0x00000042 -> PC=0x40; erroAlinhamento=1 and stays 1 until reset.
REQ-034 ROM word 0x00000000 at 0x10 -> parado=1, PC stays 0x10, validoID=0; later desvio=1 is ignored; reset returns all outputs to REQ-026 values.
REQ-035 Force PC to 0xFFFFFFFC via desvio, then one normal fetch -> imemEndereco=0x00000000, pcID=0xFFFFFFFC.
